hamming_secded_codec: RTL and testbench
=======================================

// Module: hamming_secded_codec
// PURPOSE
//  Parametrised extended-Hamming (SECDED) encoder/decoder with a registered valid/ready stage.
//  - Encode mode: K data bits -> N-bit codeword.
//  - Decode mode: corrects single-bit errors and flags double-bit errors.
//  - For K=4, codeword[6:0] is the classic (7,4) layout and bit 7 is overall parity.
//  - Sits between the user I/O wrapper and any stream source/sink.
// PARAMETERS
//  K       4   data bits per word; legal range 4..57
//  R       -   derived: smallest R with 2**R >= K+R+1; localparam, not overridable
//  N       -   derived: K+R+1, codeword width; localparam
//  CNT_W   8   width of each error counter
// PORTS
//  clk             in   1      clock, rising edge
//  rst_n           in   1      asynchronous reset, active low
//  in_valid        in   1      input word present
//  in_ready        out  1      block can accept the input word
//  mode            in   1      0 = encode, 1 = decode; sampled together with in_data on accept
//  in_data         in   N      encode: data in [K-1:0], upper bits ignored; decode: codeword
//  out_valid       out  1      result present
//  out_ready       in   1      sink accepts the result
//  out_data        out  N      encode: codeword; decode: corrected data in [K-1:0], upper bits 0
//  out_status      out  2      00 clean/encode, 01 corrected, 10 uncorrectable; 11 never driven
//  clr_cnt         in   1      synchronous clear of both error counters
//  err_corr_cnt    out  CNT_W  number of corrected words, saturating
//  err_uncorr_cnt  out  CNT_W  number of uncorrectable words, saturating
// BEHAVIOUR
//  Codeword layout
//  - Bit i, for i < N-1, holds Hamming position i+1.
//  - Parity bits sit at positions 1,2,4,8,...; each is the XOR of all positions whose index has that bit set.
//  - Data bits fill the remaining positions in ascending order, d0 first.
//  - Bit N-1 makes the XOR of all N bits even.
//  Handshake
//  - in_ready = !out_valid | out_ready (combinational).
//  - Accept = in_valid & in_ready.
//  - Latency is 1 cycle: the result is registered on the accept edge and out_valid rises on that edge.
//  - If nothing is accepted while out_valid & out_ready, out_valid drops.
//  - While out_valid & !out_ready, out_data and out_status hold stable.
//  - Back-to-back accepts give full throughput (1 word per cycle).
//  Decode
//  - syn = XOR over set-bit positions of bits [N-2:0]; P = XOR of all N bits.
//  - syn=0, P=0: status 00.
//  - syn=0, P=1: overall parity bit in error; data unchanged; status 01.
//  - syn!=0, P=1, syn <= N-1: flip position syn, then extract data; status 01.
//  - syn!=0, P=0: double error; data extracted uncorrected; status 10.
//  - syn > N-1 (impossible position): status 10.
//  Counters
//  - Increment on accept of a decode word with status 01 (corr) or 10 (uncorr).
//  - Saturate at all-ones.
//  - clr_cnt wins over an increment in the same cycle; the counters read 0 next cycle.
//  Reset values: out_valid=0, out_data=0, out_status=00, both counters=0. in_ready=1 after reset.
//  Reset mid-operation: a pending output is discarded; no partial state survives.
//  mode is per word; mixing encode and decode back-to-back is legal.
// CONFIGURATION
//  HAMMING_ERR_COUNT_EN defined
//  - Counters and clr_cnt behave as above.
//  HAMMING_ERR_COUNT_EN undefined
//  - Counter registers are not built.
//  - err_corr_cnt and err_uncorr_cnt are tied to 0; clr_cnt is ignored.
//  - Port list is unchanged; datapath and handshake are identical.
// TESTING  (K=4, N=8, CNT_W=8, macro defined unless stated)
//  1. Encode in_data=8'h0B, out_ready=1 -> next cycle out_data=8'h55, status 00; sweep all 16 inputs against the golden model.
//  2. Decode 8'h55 -> out_data=8'h0B, status 00.
//     Decode 8'h51 (bit 2 flipped) -> 8'h0B, status 01, err_corr_cnt=1.
//     Decode 8'hD5 (bit 7 flipped) -> 8'h0B, status 01.
//  3. Decode 8'h56 (bits 0,1 flipped) -> status 10, err_uncorr_cnt=1; every 2-bit flip of every codeword gives status 10.
//  4. Stream 4 words with out_ready low for 3 cycles -> in_ready=0 and out_data stable while stalled; no word lost or duplicated.
//  5. Force 260 correctable decodes -> err_corr_cnt saturates at 8'hFF.
//     Assert clr_cnt together with a correctable word -> counter reads 0.
//  6. Drop rst_n while out_valid=1 and out_ready=0 -> out_valid=0 immediately.
//     Rebuild without HAMMING_ERR_COUNT_EN -> counters stay 0 and the datapath matches scenarios 1-3.

Source files
------------

// File: rtl/hamming_secded_codec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hamming_secded_codec                                          |
// | Purpose  : Extended-Hamming SECDED encoder/decoder, 1-cycle valid/ready. |
// | Options  : HAMMING_ERR_COUNT_EN builds the saturating error counters.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module hamming_secded_codec #(
  parameter  int K     = 4,
  parameter  int CNT_W = 8,
  localparam int R     = (K <= 4) ? 3 : (K <= 11) ? 4 : (K <= 26) ? 5 : (K <= 57) ? 6 : 7,
  localparam int N     = K + R + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [1:0]       out_status,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_corr_cnt,
  output logic [CNT_W-1:0] err_uncorr_cnt
);

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_CORR   = 2'b01;
  localparam logic [1:0] ST_UNCORR = 2'b10;

  // Bit i of a codeword carries Hamming position i+1; powers of two are parity.
  function automatic logic [N-1:0] f_encode(input logic [K-1:0] d);
    logic [N-1:0] cw;
    logic         par;
    int           di;
    cw = '0;
    di = 0;
    for (int p = 1; p < N; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[di];
        di++;
      end
    end
    for (int j = 0; j < R; j++) begin
      par = 1'b0;
      for (int p = 1; p < N; p++) begin
        if (p[j]) par ^= cw[p-1];
      end
      cw[(1 << j) - 1] = par;
    end
    cw[N-1] = ^cw[N-2:0];
    return cw;
  endfunction

  function automatic logic [R-1:0] f_syndrome(input logic [N-1:0] cw);
    logic [R-1:0] syn;
    syn = '0;
    for (int p = 1; p < N; p++) begin
      if (cw[p-1]) syn ^= p[R-1:0];
    end
    return syn;
  endfunction

  function automatic logic [K-1:0] f_extract(input logic [N-1:0] cw);
    logic [K-1:0] d;
    int           di;
    d  = '0;
    di = 0;
    for (int p = 1; p < N; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[di] = cw[p-1];
        di++;
      end
    end
    return d;
  endfunction

  logic [R-1:0] syn;
  logic         par_all;
  logic         syn_in_range;
  logic [N-1:0] fixed_cw;
  logic [N-1:0] dec_data;
  logic [1:0]   dec_status;
  logic [N-1:0] enc_data;
  logic         accept;

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_data_q,  out_data_d;
  logic [1:0]   out_status_q, out_status_d;

  always_comb begin
    syn          = f_syndrome(in_data);
    par_all      = ^in_data;
    fixed_cw     = in_data;
    syn_in_range = 1'b0;
    dec_status   = ST_CLEAN;
    // Flip only a real position; a syndrome beyond N-1 is left untouched.
    for (int p = 1; p < N; p++) begin
      if (syn == p[R-1:0]) begin
        syn_in_range  = 1'b1;
        fixed_cw[p-1] = ~in_data[p-1];
      end
    end
    if (syn == '0) begin
      fixed_cw   = in_data;
      dec_status = par_all ? ST_CORR : ST_CLEAN;
    end else if (!par_all) begin
      fixed_cw   = in_data;
      dec_status = ST_UNCORR;
    end else if (!syn_in_range) begin
      dec_status = ST_UNCORR;
    end else begin
      dec_status = ST_CORR;
    end
    dec_data        = '0;
    dec_data[K-1:0] = f_extract(fixed_cw);
    enc_data        = f_encode(in_data[K-1:0]);
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_status_d = out_status_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_data_d   = mode ? dec_data : enc_data;
      out_status_d = mode ? dec_status : ST_CLEAN;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_status_q <= ST_CLEAN;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_status_q <= out_status_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_status = out_status_q;

`ifdef HAMMING_ERR_COUNT_EN
  logic [CNT_W-1:0] err_corr_cnt_q,   err_corr_cnt_d;
  logic [CNT_W-1:0] err_uncorr_cnt_q, err_uncorr_cnt_d;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    err_corr_cnt_d   = err_corr_cnt_q;
    err_uncorr_cnt_d = err_uncorr_cnt_q;
    if (clr_cnt) begin
      err_corr_cnt_d   = '0;
      err_uncorr_cnt_d = '0;
    end else if (accept && mode) begin
      if (dec_status == ST_CORR && err_corr_cnt_q != '1)
        err_corr_cnt_d = err_corr_cnt_q + CNT_ONE;
      if (dec_status == ST_UNCORR && err_uncorr_cnt_q != '1)
        err_uncorr_cnt_d = err_uncorr_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_corr_cnt_q   <= '0;
      err_uncorr_cnt_q <= '0;
    end else begin
      err_corr_cnt_q   <= err_corr_cnt_d;
      err_uncorr_cnt_q <= err_uncorr_cnt_d;
    end
  end

  assign err_corr_cnt   = err_corr_cnt_q;
  assign err_uncorr_cnt = err_uncorr_cnt_q;
`else
  logic clr_cnt_unused;
  assign clr_cnt_unused = clr_cnt;
  assign err_corr_cnt   = '0;
  assign err_uncorr_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_codec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hamming_secded_codec                                       |
// | Purpose  : Directed self-checking bench for the K=4 SECDED codec.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_hamming_secded_codec;

`ifdef HAMMING_ERR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       mode;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_status;
  logic       clr_cnt;
  logic [7:0] err_corr_cnt;
  logic [7:0] err_uncorr_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hamming_secded_codec #(.K(4), .CNT_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mode           (mode),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_status     (out_status),
    .clr_cnt        (clr_cnt),
    .err_corr_cnt   (err_corr_cnt),
    .err_uncorr_cnt (err_uncorr_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Classic (7,4): p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3; bit 7 is even parity.
  function automatic logic [7:0] gold_enc(input logic [3:0] d);
    logic [7:0] cw;
    cw[0] = d[0] ^ d[1] ^ d[3];
    cw[1] = d[0] ^ d[2] ^ d[3];
    cw[2] = d[0];
    cw[3] = d[1] ^ d[2] ^ d[3];
    cw[4] = d[1];
    cw[5] = d[2];
    cw[6] = d[3];
    cw[7] = ^cw[6:0];
    return cw;
  endfunction

  function automatic logic [7:0] cnt_exp(input logic [7:0] v);
    return CNT_EN ? v : 8'h00;
  endfunction

  task automatic send(input logic m, input logic [7:0] d, input logic clr);
    @(negedge clk);
    in_valid = 1'b1;
    mode     = m;
    in_data  = d;
    clr_cnt  = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  initial begin
    logic [7:0] rx[$];
    logic [7:0] held;
    logic [7:0] cw;
    logic [7:0] bad;
    logic       was_stall;
    logic       acc;
    int         idx;

    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; in_data = '0;
    out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_status", out_status, 0);
    check("rst_corr_cnt", err_corr_cnt, 0);
    check("rst_uncorr_cnt", err_uncorr_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    send(1'b0, 8'h0B, 1'b0);
    check("enc_0b_valid", out_valid, 1);
    check("enc_0b_data", out_data, 8'h55);
    check("enc_0b_status", out_status, 0);
    for (int d = 0; d < 16; d++) begin
      send(1'b0, 8'(d) | 8'hF0, 1'b0);
      check("enc_sweep_data", out_data, gold_enc(4'(d)));
      check("enc_sweep_status", out_status, 0);
    end

    send(1'b1, 8'h55, 1'b0);
    check("dec_55_data", out_data, 8'h0B);
    check("dec_55_status", out_status, 0);
    check("dec_55_corr_cnt", err_corr_cnt, 0);
    send(1'b1, 8'h51, 1'b0);
    check("dec_51_data", out_data, 8'h0B);
    check("dec_51_status", out_status, 1);
    check("dec_51_corr_cnt", err_corr_cnt, cnt_exp(8'd1));
    send(1'b1, 8'hD5, 1'b0);
    check("dec_d5_data", out_data, 8'h0B);
    check("dec_d5_status", out_status, 1);
    check("dec_d5_corr_cnt", err_corr_cnt, cnt_exp(8'd2));
    send(1'b1, 8'h56, 1'b0);
    check("dec_56_status", out_status, 2);
    check("dec_56_uncorr_cnt", err_uncorr_cnt, cnt_exp(8'd1));

    for (int d = 0; d < 16; d++) begin
      cw = gold_enc(4'(d));
      send(1'b1, cw, 1'b0);
      check("dec_clean_data", out_data, 8'(d));
      for (int i = 0; i < 8; i++) begin
        bad = cw;
        bad[i] = ~bad[i];
        send(1'b1, bad, 1'b0);
        check("dec_1flip_data", out_data, 8'(d));
        check("dec_1flip_status", out_status, 1);
        for (int j = i + 1; j < 8; j++) begin
          bad = cw;
          bad[i] = ~bad[i];
          bad[j] = ~bad[j];
          send(1'b1, bad, 1'b0);
          check("dec_2flip_status", out_status, 2);
        end
      end
    end

    // Stall the sink for three cycles while four encode words are offered.
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    idx = 0;
    was_stall = 1'b0;
    held = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = !(c >= 1 && c <= 3);
      in_valid  = (idx < 4);
      mode      = 1'b0;
      in_data   = 8'(idx + 3);
      #1;
      acc = in_valid && in_ready;
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        if (was_stall) check("stall_hold_data", out_data, held);
        held = out_data;
        was_stall = 1'b1;
      end else begin
        was_stall = 1'b0;
      end
      if (out_valid && out_ready) rx.push_back(out_data);
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", rx.size(), 4);
    for (int i = 0; i < rx.size() && i < 4; i++)
      check("stream_word", rx[i], gold_enc(4'(i + 3)));

    for (int i = 0; i < 260; i++) send(1'b1, 8'h51, 1'b0);
    check("sat_corr_cnt", err_corr_cnt, cnt_exp(8'hFF));
    check("sat_uncorr_cnt", err_uncorr_cnt, cnt_exp(8'hFF));
    send(1'b1, 8'h51, 1'b1);
    check("clr_corr_cnt", err_corr_cnt, 0);
    check("clr_uncorr_cnt", err_uncorr_cnt, 0);
    check("clr_word_status", out_status, 1);

    @(negedge clk);
    out_ready = 1'b1;
    send(1'b0, 8'h0B, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_status", out_status, 0);
    check("async_rst_corr_cnt", err_corr_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    send(1'b0, 8'h0B, 1'b0);
    check("post_rst_enc", out_data, 8'h55);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
